fp_mul_sign_exp: RTL and testbench

Parametrised, pipelined sign and exponent front end for the IEEE-754 floating-point multiplier. It accepts two packed operands and produces the result sign, the unnormalised biased exponent and a special-case class two cycles later, using a valid/ready handshake with full backpressure. It replaces the single-precision, combinational-only sign stage. It feeds the mantissa-multiply/normalise stage, which consumes `exp_raw` and the overflow/underflow flags.

---
 rtl/fp_mul_sign_exp.sv | 136 +++++++++++++
 tb/tb_fp_mul_sign_exp.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_sign_exp.sv
// Sign/exponent front end of the IEEE-754 multiplier: two-stage valid/ready
// pipeline producing result sign, unnormalised biased exponent and special class.
module fp_mul_sign_exp #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in1,
  input  logic [EXP_W+MAN_W:0]   in2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign,
  output logic [EXP_W+1:0]       exp_raw,
  output logic [1:0]             cls,
  output logic                   ovf,
  output logic                   unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] OVF_LIM = XW'((1 << EXP_W) - 1);

  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  // Handshake: a beat transfers on valid && ready at a rising edge. S2 moves
  // when its slot is empty or being drained; S1 moves when empty or S2 moves,
  // so in_ready is combinational from out_ready and the two valid bits.
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Operand field decode (denormals flush to zero)
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] m1, m2;
  logic             z1, i1, n1, z2, i2, n2;

  always_comb begin
    e1 = in1[W-2 -: EXP_W];
    e2 = in2[W-2 -: EXP_W];
    m1 = in1[MAN_W-1:0];
    m2 = in2[MAN_W-1:0];
    z1 = (e1 == '0);
    z2 = (e2 == '0);
    i1 = (&e1) && (m1 == '0);
    i2 = (&e2) && (m2 == '0);
    n1 = (&e1) && (m1 != '0);
    n2 = (&e2) && (m2 != '0);
  end

  // Stage 1 registers
  logic             s1_s;
  logic [EXP_W-1:0] s1_e1, s1_e2;
  logic             s1_z1, s1_i1, s1_n1, s1_z2, s1_i2, s1_n2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= 1'b0;
      s1_e1    <= '0;
      s1_e2    <= '0;
      s1_z1    <= 1'b0;
      s1_i1    <= 1'b0;
      s1_n1    <= 1'b0;
      s1_z2    <= 1'b0;
      s1_i2    <= 1'b0;
      s1_n2    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_s  <= in1[W-1] ^ in2[W-1];
        s1_e1 <= e1;
        s1_e2 <= e2;
        s1_z1 <= z1;
        s1_i1 <= i1;
        s1_n1 <= n1;
        s1_z2 <= z2;
        s1_i2 <= i2;
        s1_n2 <= n2;
      end
    end
  end

  // Stage 2 next values
  logic [XW-1:0] exp_c;
  logic [1:0]    cls_c;
  logic          sign_c;
  logic          ovf_c;
  logic          unf_c;

  always_comb begin
    exp_c = {2'b00, s1_e1} + {2'b00, s1_e2} - BIAS;
    cls_c = CLS_NORM;
    // inf x zero is invalid and lands in the NaN class
    if (s1_n1 || s1_n2 || (s1_i1 && s1_z2) || (s1_i2 && s1_z1))
      cls_c = CLS_NAN;
    else if (s1_i1 || s1_i2)
      cls_c = CLS_INF;
    else if (s1_z1 || s1_z2)
      cls_c = CLS_ZERO;
    sign_c = (cls_c == CLS_NAN) ? 1'b0 : s1_s;
    ovf_c  = (cls_c == CLS_NORM) && ($signed(exp_c) >= $signed(OVF_LIM));
    unf_c  = (cls_c == CLS_NORM) && (exp_c[XW-1] || (exp_c == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sign      <= 1'b0;
      exp_raw   <= '0;
      cls       <= CLS_NORM;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign    <= sign_c;
        exp_raw <= exp_c;
        cls     <= cls_c;
        ovf     <= ovf_c;
        unf     <= unf_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_sign_exp.sv
// Directed bench for fp_mul_sign_exp: single-precision vectors, backpressure,
// mid-stream reset, and a binary16 instance.
module tb_fp_mul_sign_exp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1, in2;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [9:0]  exp_raw;
  logic [1:0]  cls;
  logic        ovf, unf;

  logic        h_in_valid;
  logic        h_in_ready;
  logic [15:0] h_in1, h_in2;
  logic        h_out_valid;
  logic        h_out_ready;
  logic        h_sign;
  logic [6:0]  h_exp_raw;
  logic [1:0]  h_cls;
  logic        h_ovf, h_unf;

  int n_cmp = 0;
  int n_err = 0;
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  fp_mul_sign_exp #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .exp_raw(exp_raw), .cls(cls), .ovf(ovf), .unf(unf)
  );

  fp_mul_sign_exp #(.EXP_W(5), .MAN_W(10)) u_dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in1(h_in1), .in2(h_in2), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .sign(h_sign), .exp_raw(h_exp_raw), .cls(h_cls), .ovf(h_ovf), .unf(h_unf)
  );

  // Present one pair with out_ready high and capture the first result.
  task automatic drive_pair(input logic [31:0] a, input logic [31:0] b,
                            output logic [14:0] got, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    got = '0;
    @(negedge clk);
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 8 && !in_ready; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got = {sign, exp_raw, cls, ovf, unf};
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    n_cmp++;
    if ({sign, exp_raw, cls, ovf, unf} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", {sign, exp_raw, cls, ovf, unf});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_vectors;
    logic [31:0] va [14] = '{32'h3F800000, 32'hBFC00000, 32'hBF800000, 32'hFFFFFFF0,
                             32'h7F800000, 32'hFF800000, 32'h80000000, 32'h7F000000,
                             32'h00800000, 32'h7F000000, 32'h00800000, 32'h00800000,
                             32'hFFC00000, 32'h7F000000};
    logic [31:0] vb [14] = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'h00000003,
                             32'h00000000, 32'h3F800000, 32'h3F800000, 32'h7F000000,
                             32'h00800000, 32'h40000000, 32'h3F000000, 32'h3F800000,
                             32'h3F800000, 32'h3F800000};
    logic [14:0] ve [14] = '{{1'b0, 10'd128,  2'b00, 1'b0, 1'b0},
                             {1'b1, 10'd128,  2'b00, 1'b0, 1'b0},
                             {1'b0, 10'd128,  2'b00, 1'b0, 1'b0},
                             {1'b0, 10'd128,  2'b11, 1'b0, 1'b0},
                             {1'b0, 10'd128,  2'b11, 1'b0, 1'b0},
                             {1'b1, 10'd255,  2'b10, 1'b0, 1'b0},
                             {1'b1, 10'd0,    2'b01, 1'b0, 1'b0},
                             {1'b0, 10'd381,  2'b00, 1'b1, 1'b0},
                             {1'b0, 10'h383,  2'b00, 1'b0, 1'b1},
                             {1'b0, 10'd255,  2'b00, 1'b1, 1'b0},
                             {1'b0, 10'd0,    2'b00, 1'b0, 1'b1},
                             {1'b0, 10'd1,    2'b00, 1'b0, 1'b0},
                             {1'b0, 10'd255,  2'b11, 1'b0, 1'b0},
                             {1'b0, 10'd254,  2'b00, 1'b0, 1'b0}};
    string nm [14] = '{"one_x_two", "neg_sign", "neg_neg", "nan_x_zero", "inf_x_zero",
                       "neg_inf", "neg_zero", "ovf_381", "unf_m125", "ovf_edge_255",
                       "unf_edge_0", "unf_edge_1", "neg_nan_canon", "no_ovf_254"};
    logic [14:0] got;
    int lat;
    bit ok;
    for (int i = 0; i < 14; i++) begin
      drive_pair(va[i], vb[i], got, lat, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s_timeout got=no_output exp=output_within_8", nm[i]);
      end else begin
        n_cmp++;
        if (lat !== 2) begin
          n_err++;
          $display("FAIL %s_latency got=%0d exp=2", nm[i], lat);
        end
        n_cmp++;
        if (got !== ve[i]) begin
          n_err++;
          $display("FAIL %s got=%h exp=%h", nm[i], got, ve[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ba [4] = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h40800000};
    logic [31:0] bb [4] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'hBF800000};
    logic [14:0] be [4] = '{{1'b0, 10'd127, 2'b00, 1'b0, 1'b0},
                            {1'b0, 10'd129, 2'b00, 1'b0, 1'b0},
                            {1'b1, 10'd128, 2'b00, 1'b0, 1'b0},
                            {1'b1, 10'd129, 2'b00, 1'b0, 1'b0}};
    int sent;
    int got_n;
    int gaps;
    logic [14:0] want;
    sent = 0;
    got_n = 0;
    gaps = 0;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in1 = ba[sent];
      in2 = bb[sent];
      in_valid = 1'b1;
      out_ready = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(be[sent]);
        sent++;
      end
    end
    n_cmp++;
    if (sent !== 2) begin
      n_err++;
      $display("FAIL bp_accepted got=%0d exp=2", sent);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_in_ready got=%b exp=0", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, sign, exp_raw, cls, ovf, unf} !== {1'b1, be[0]}) begin
        n_err++;
        $display("FAIL bp_hold got=%h exp=%h", {out_valid, sign, exp_raw, cls, ovf, unf},
                 {1'b1, be[0]});
      end
    end
    for (int c = 0; c < 12 && got_n < 4; c++) begin
      @(negedge clk);
      if (sent < 4) begin
        in1 = ba[sent];
        in2 = bb[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h7FFF;
        n_cmp++;
        if ({sign, exp_raw, cls, ovf, unf} !== want) begin
          n_err++;
          $display("FAIL bp_order_%0d got=%h exp=%h", got_n, {sign, exp_raw, cls, ovf, unf}, want);
        end
        got_n++;
      end else if (got_n > 0) begin
        gaps++;
      end
      if (in_valid && in_ready && sent < 4) begin
        exp_q.push_back(be[sent]);
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (got_n !== 4) begin
      n_err++;
      $display("FAIL bp_delivered got=%0d exp=4", got_n);
    end
    n_cmp++;
    if (gaps !== 0) begin
      n_err++;
      $display("FAIL bp_gaps got=%0d exp=0", gaps);
    end
  endtask

  task automatic test_reset_midstream;
    int stale;
    stale = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in1 = 32'h3F800000;
      in2 = 32'h40000000;
      in_valid = 1'b1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_fill got=%b exp=1", out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    in1 = 32'h40000000;
    in2 = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, sign, exp_raw, cls, ovf, unf} !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs got=%h exp=0", {out_valid, sign, exp_raw, cls, ovf, unf});
    end
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin
      n_err++;
      $display("FAIL mid_stale got=%0d exp=0", stale);
    end
  endtask

  task automatic test_binary16;
    logic [15:0] ha [3] = '{16'h3C00, 16'h7C00, 16'h7800};
    logic [15:0] hb [3] = '{16'h4000, 16'h0000, 16'h7800};
    logic [11:0] he [3] = '{{1'b0, 7'd16, 2'b00, 1'b0, 1'b0},
                            {1'b0, 7'd16, 2'b11, 1'b0, 1'b0},
                            {1'b0, 7'd45, 2'b00, 1'b1, 1'b0}};
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      h_in1 = ha[i];
      h_in2 = hb[i];
      h_in_valid = 1'b1;
      @(posedge clk);
      #1 h_in_valid = 1'b0;
      ok = 1'b0;
      lat = 0;
      for (int c = 0; c < 8 && !ok; c++) begin
        @(negedge clk);
        lat++;
        if (h_out_valid) ok = 1'b1;
      end
      n_cmp++;
      if (!ok || lat !== 2) begin
        n_err++;
        $display("FAIL h16_latency_%0d got=%0d exp=2", i, ok ? lat : -1);
      end
      n_cmp++;
      if ({h_sign, h_exp_raw, h_cls, h_ovf, h_unf} !== he[i]) begin
        n_err++;
        $display("FAIL h16_result_%0d got=%h exp=%h", i,
                 {h_sign, h_exp_raw, h_cls, h_ovf, h_unf}, he[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in1 = '0;
    in2 = '0;
    h_in_valid = 1'b0;
    h_out_ready = 1'b1;
    h_in1 = '0;
    h_in2 = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midstream();
    test_binary16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
